// File: rtl/button_pkg.sv
// Shared defaults and the per-channel status record for the button bank.
package button_pkg;

  // Integrator width that gives roughly 1.3 ms of debounce at 50 MHz.
  localparam int CNT_WIDTH_DEF = 16;

  // Long-press counter width, wide enough to hold LONG_CYCLES_DEF.
  localparam int HOLD_WIDTH_DEF = 26;

  // One second at 50 MHz.
  localparam int unsigned LONG_CYCLES_DEF = 32'd50_000_000;

  // Everything one channel reports, all registered.
  // The release strobe is called 'rel' because 'release' is a reserved word.
  typedef struct packed {
    logic level;
    logic press;
    logic rel;
    logic long_press;
    logic long_pulse;
  } chan_status_t;

endpackage

// File: rtl/button_channel.sv
// One debounced button: input polarity fix, 2-flop synchroniser, saturating
// up/down integrator with hysteresis, edge strobes and long-press detection.
module button_channel
  import button_pkg::*;
#(
  parameter int          CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int          HOLD_WIDTH  = HOLD_WIDTH_DEF,
  parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEF,
  parameter logic        ACTIVE_LOW  = 1'b0
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         button_in,
  output chan_status_t status
);

  localparam logic [CNT_WIDTH-1:0]  CNT_MAX     = '1;
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE     = CNT_WIDTH'(1);
  localparam logic [HOLD_WIDTH-1:0] HOLD_TARGET = HOLD_WIDTH'(LONG_CYCLES);
  localparam logic [HOLD_WIDTH-1:0] HOLD_ONE    = HOLD_WIDTH'(1);

  logic                  pin;
  logic                  sync1;
  logic                  sync2;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  level_q;
  logic                  level_nxt;
  logic                  press_q;
  logic                  rel_q;
  logic [HOLD_WIDTH-1:0] hold;
  logic                  hold_done;
  logic                  long_press_q;
  logic                  long_pulse_q;

  // Normalise polarity so that 1 always means "pressed" from here on.
  assign pin = button_in ^ ACTIVE_LOW;

  // Two-flop synchroniser for the asynchronous pin.
  // NOTE: every clocked block uses non-blocking assignments so that all flops
  // sample the pre-edge values; a blocking '=' here would collapse sync1/sync2
  // into a single stage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

  // Saturating integrator: counts toward all-ones while pressed and toward
  // zero while released, never wrapping at either end.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (sync2 && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_ONE;
    end else if (!sync2 && (cnt != '0)) begin
      cnt <= cnt - CNT_ONE;
    end
  end

  // Hysteresis decision: only the two integrator extremes move the level.
  // NOTE: the default assignment first keeps this purely combinational; leaving
  // level_nxt unassigned on the "hold" path would infer a latch.
  always_comb begin
    level_nxt = level_q;
    if (cnt == CNT_MAX) begin
      level_nxt = 1'b1;
    end else if (cnt == '0) begin
      level_nxt = 1'b0;
    end
  end

  // Debounced level and its edge strobes, registered together so each strobe
  // is high in exactly the first cycle the new level is visible.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      level_q <= level_nxt;
      press_q <= level_nxt & ~level_q;
      rel_q   <= ~level_nxt & level_q;
    end
  end

  // Hold counter: counts debounced-pressed cycles, saturating at the target,
  // and restarts from zero whenever the level is low.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold <= '0;
    end else if (!level_q) begin
      hold <= '0;
    end else if (hold != HOLD_TARGET) begin
      hold <= hold + HOLD_ONE;
    end
  end

  assign hold_done = (hold == HOLD_TARGET);

  // Long-press flag and its rising strobe; gating with level_nxt makes the
  // flag drop on the same edge as level and blocks a late strobe on release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      long_press_q <= 1'b0;
      long_pulse_q <= 1'b0;
    end else begin
      long_press_q <= level_nxt & (long_press_q | hold_done);
      long_pulse_q <= level_nxt & hold_done & ~long_press_q;
    end
  end

  assign status = '{
    level:      level_q,
    press:      press_q,
    rel:        rel_q,
    long_press: long_press_q,
    long_pulse: long_pulse_q
  };

endmodule

// File: rtl/button_bank.sv
// Bank of independent debounced buttons; one button_channel per pin.
module button_bank
  import button_pkg::*;
#(
  parameter int                  CHANNELS    = 4,
  parameter int                  CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int                  HOLD_WIDTH  = HOLD_WIDTH_DEF,
  parameter int unsigned         LONG_CYCLES = LONG_CYCLES_DEF,
  parameter logic [CHANNELS-1:0] ACTIVE_LOW  = '0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] button_in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] long_press,
  output logic [CHANNELS-1:0] long_pulse
);

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
    chan_status_t status;

    button_channel #(
      .CNT_WIDTH  (CNT_WIDTH),
      .HOLD_WIDTH (HOLD_WIDTH),
      .LONG_CYCLES(LONG_CYCLES),
      .ACTIVE_LOW (ACTIVE_LOW[ch])
    ) u_channel (
      .clock    (clock),
      .reset_n  (reset_n),
      .button_in(button_in[ch]),
      .status   (status)
    );

    assign level[ch]         = status.level;
    assign press_pulse[ch]   = status.press;
    assign release_pulse[ch] = status.rel;
    assign long_press[ch]    = status.long_press;
    assign long_pulse[ch]    = status.long_pulse;
  end

endmodule

// File: tb/tb_button_bank.sv
// Directed bench for button_bank with a 4-cycle-wide debounce window.
// Time reference: inputs change 1 time unit after an edge ("edge 0"); outputs
// are sampled 1 time unit after each following edge.
module tb_button_bank;

  localparam int CH = 4;

  logic          clock;
  logic          reset_n;
  logic [CH-1:0] button_in;
  logic [CH-1:0] level;
  logic [CH-1:0] press_pulse;
  logic [CH-1:0] release_pulse;
  logic [CH-1:0] long_press;
  logic [CH-1:0] long_pulse;

  int checks = 0;
  int errors = 0;
  int press_cnt [CH];
  int rel_cnt   [CH];
  int lp_cnt    [CH];
  int snap_press;
  int snap_rel;

  button_bank #(
    .CHANNELS   (CH),
    .CNT_WIDTH  (4),
    .HOLD_WIDTH (8),
    .LONG_CYCLES(32),
    .ACTIVE_LOW (4'b1000)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .button_in    (button_in),
    .level        (level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_press   (long_press),
    .long_pulse   (long_pulse)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance n edges; tally every strobe and check press/release exclusivity.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      for (int c = 0; c < CH; c++) begin
        if (press_pulse[c])   press_cnt[c]++;
        if (release_pulse[c]) rel_cnt[c]++;
        if (long_pulse[c])    lp_cnt[c]++;
      end
      check("press_release_exclusive", 32'(press_pulse & release_pulse), 32'h0);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({level, press_pulse, release_pulse, long_press, long_pulse});
  endfunction

  initial begin
    for (int c = 0; c < CH; c++) begin
      press_cnt[c] = 0;
      rel_cnt[c]   = 0;
      lp_cnt[c]    = 0;
    end
    reset_n   = 1'b0;
    button_in = 4'b1000;  // ch3 idles high (active-low pin)

    // Reset behaviour
    tick(3);
    check("reset_outputs", all_outs(), 32'h0);
    reset_n = 1'b1;
    tick(1);
    check("first_edge_after_reset", all_outs(), 32'h0);
    tick(20);
    check("idle_after_reset", all_outs(), 32'h0);

    // Clean press on ch0: level and press strobe at edge 18
    button_in[0] = 1'b1;
    tick(17);
    check("ch0_level_e17", 32'(level), 32'h0);
    tick(1);
    check("ch0_level_e18", 32'(level), 32'h1);
    check("ch0_press_e18", 32'(press_pulse), 32'h1);
    tick(1);
    check("ch0_press_e19", 32'(press_pulse), 32'h0);
    check("ch0_level_e19", 32'(level), 32'h1);
    // Early release: level falls 18 edges later, hold never reaches 32
    button_in[0] = 1'b0;
    tick(17);
    check("ch0_level_before_release", 32'(level), 32'h1);
    tick(1);
    check("ch0_level_released", 32'(level), 32'h0);
    check("ch0_release_pulse", 32'(release_pulse), 32'h1);
    check("ch0_no_long_press", 32'(long_press), 32'h0);
    tick(2);
    check("ch0_press_count", 32'(press_cnt[0]), 32'd1);
    check("ch0_release_count", 32'(rel_cnt[0]), 32'd1);
    check("ch0_no_long_pulse", 32'(lp_cnt[0]), 32'd0);
    // Second press: hold restarts from 0, long press exactly 33 after level
    button_in[0] = 1'b1;
    tick(18);
    check("ch0_repress_level", 32'(level), 32'h1);
    tick(32);
    check("ch0_long_not_yet", 32'(long_press), 32'h0);
    tick(1);
    check("ch0_long_press_33", 32'(long_press), 32'h1);
    check("ch0_long_pulse_33", 32'(long_pulse), 32'h1);
    button_in[0] = 1'b0;
    tick(18);
    check("ch0_long_cleared", 32'(long_press), 32'h0);
    check("ch0_level_cleared", 32'(level), 32'h0);
    tick(2);

    // Bounce on ch1: 10 high, 3 low, then high -> level at edge 24
    snap_press = press_cnt[1];
    button_in[1] = 1'b1;
    tick(10);
    button_in[1] = 1'b0;
    tick(3);
    button_in[1] = 1'b1;
    tick(10);
    check("ch1_level_e23", 32'(level), 32'h0);
    tick(1);
    check("ch1_level_e24", 32'(level), 32'h2);
    check("ch1_press_e24", 32'(press_pulse), 32'h2);
    tick(5);
    check("ch1_single_press", 32'(press_cnt[1] - snap_press), 32'd1);
    button_in[1] = 1'b0;
    tick(18);
    check("ch1_released", 32'(level), 32'h0);
    check("ch1_no_long_pulse", 32'(lp_cnt[1]), 32'd0);
    tick(2);

    // Long press on ch2: long_press/long_pulse 33 edges after level rises
    button_in[2] = 1'b1;
    tick(18);
    check("ch2_level", 32'(level), 32'h4);
    tick(32);
    check("ch2_long_e32", 32'(long_press), 32'h0);
    check("ch2_long_pulse_e32", 32'(long_pulse), 32'h0);
    tick(1);
    check("ch2_long_e33", 32'(long_press), 32'h4);
    check("ch2_long_pulse_e33", 32'(long_pulse), 32'h4);
    tick(1);
    check("ch2_long_pulse_once", 32'(long_pulse), 32'h0);
    check("ch2_long_held", 32'(long_press), 32'h4);
    tick(20);
    check("ch2_long_pulse_count", 32'(lp_cnt[2]), 32'd1);
    button_in[2] = 1'b0;
    tick(17);
    check("ch2_long_before_release", 32'(long_press), 32'h4);
    tick(1);
    check("ch2_level_release", 32'(level), 32'h0);
    check("ch2_long_with_level", 32'(long_press), 32'h0);
    check("ch2_release_pulse", 32'(release_pulse), 32'h4);
    tick(2);
    check("ch2_release_count", 32'(rel_cnt[2]), 32'd1);

    // Active-low ch3: pin 0 presses, pin 1 releases, 18 edges each
    button_in[3] = 1'b0;
    tick(17);
    check("ch3_level_e17", 32'(level), 32'h0);
    tick(1);
    check("ch3_level_e18", 32'(level), 32'h8);
    check("ch3_press_e18", 32'(press_pulse), 32'h8);
    button_in[3] = 1'b1;
    tick(17);
    check("ch3_release_e17", 32'(release_pulse), 32'h0);
    tick(1);
    check("ch3_release_e18", 32'(release_pulse), 32'h8);
    check("ch3_level_low", 32'(level), 32'h0);
    tick(2);

    // Simultaneous press and release on all channels
    button_in = 4'b0111;
    tick(17);
    check("all_level_e17", 32'(level), 32'h0);
    tick(1);
    check("all_press_same_cycle", 32'(press_pulse), 32'hF);
    check("all_level_e18", 32'(level), 32'hF);
    button_in = 4'b1000;
    tick(18);
    check("all_release_same_cycle", 32'(release_pulse), 32'hF);
    check("all_level_low", 32'(level), 32'h0);
    tick(2);

    // Reset at edge 12 of a ch0 press, released at edge 20 while held
    snap_press = press_cnt[0];
    snap_rel   = rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3];
    button_in[0] = 1'b1;
    tick(12);
    reset_n = 1'b0;
    #1;
    check("mid_press_reset_async", all_outs(), 32'h0);
    tick(8);
    check("mid_press_in_reset", all_outs(), 32'h0);
    reset_n = 1'b1;
    tick(1);
    check("mid_press_first_edge", all_outs(), 32'h0);
    tick(16);
    check("mid_press_level_e37", 32'(level), 32'h0);
    tick(1);
    check("mid_press_level_e38", 32'(level), 32'h1);
    check("mid_press_pulse_e38", 32'(press_pulse), 32'h1);
    tick(3);
    check("mid_press_one_press", 32'(press_cnt[0] - snap_press), 32'd1);
    check("mid_press_no_release",
          32'(rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3] - snap_rel), 32'd0);

    button_in[0] = 1'b0;
    tick(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_bank.md
BUTTON_BANK -- requirements
Module: button_bank

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent button channels, range 1..32.
REQ-002 Parameter CNT_WIDTH, default 16: debounce integrator width; 16 suits a 50 MHz clock; range 2..24.
REQ-003 Parameter HOLD_WIDTH, default 26: long-press counter width; range 2..32.
REQ-004 Parameter LONG_CYCLES, default 50_000_000: debounced-high cycles before long press; range 1..2^HOLD_WIDTH-1.
REQ-005 Parameter ACTIVE_LOW, default all zeros, CHANNELS bits: set bit inverts that channel's raw input.
REQ-006 Port list: clock  in  1  sole clock; reset_n  in  1  asynchronous active-low reset.
REQ-007 Port list: button_in  in  CHANNELS  raw asynchronous button pins.
REQ-008 Port list: level  out  CHANNELS  debounced pressed state.
REQ-009 Port list: press_pulse  out  CHANNELS  one-cycle strobe on press.
REQ-010 Port list: release_pulse  out  CHANNELS  one-cycle strobe on release.
REQ-011 Port list: long_press  out  CHANNELS  high while held at least LONG_CYCLES.
REQ-012 Port list: long_pulse  out  CHANNELS  one-cycle strobe when long_press rises.

Function
REQ-013 Each channel SHALL XOR its input with its ACTIVE_LOW bit, then pass it through a 2-flop synchroniser (sync1, sync2).
REQ-014 Integrator: +1 when sync2=1 and counter below all-ones; -1 when sync2=0 and counter nonzero; otherwise hold, with no wrap-around at either end.
REQ-015 level SHALL set on the edge after counter equals all-ones, clear on the edge after counter equals zero, and otherwise hold (hysteresis).
REQ-016 Clean-edge latency: level SHALL change exactly 2^CNT_WIDTH+2 clock edges after the input edge (18 for CNT_WIDTH=4).
REQ-017 press_pulse SHALL be registered, high exactly in the first cycle level reads 1; release_pulse likewise in the first cycle level reads 0.
REQ-018 Hold counter: reset to 0 when level=0; increment when level=1, saturating at LONG_CYCLES.
REQ-019 long_press SHALL assert the edge after the hold counter reaches LONG_CYCLES and deassert together with level.
REQ-020 long_pulse SHALL be high exactly in the first cycle long_press reads 1, at most once per press.
REQ-021 A release during hold counting SHALL clear the hold counter with no long_pulse; the next press restarts from 0.
REQ-022 Channels SHALL be fully independent; simultaneous events on any channels SHALL all be reported in the same cycle.
REQ-023 press_pulse and release_pulse of one channel SHALL never be high together.

Reset
REQ-024 With reset_n low, all flops SHALL clear asynchronously: sync stages, counters, level, pulses, long_press, long_pulse.
REQ-025 All outputs SHALL read 0 during reset and on the first edge after release.
REQ-026 No press or release pulse SHALL fire on reset deassertion, even if a button is held.
REQ-027 A held button SHALL produce level=1 with one press_pulse a full debounce latency after reset_n rises.
REQ-028 Reset mid-press or mid-bounce SHALL discard all channel state.

Structure
REQ-029 Package button_pkg SHALL hold default constants (CNT_WIDTH_DEF=16, HOLD_WIDTH_DEF=26, LONG_CYCLES_DEF=50_000_000) and a channel-status typedef {level, press, release, long_press, long_pulse}.
REQ-030 A single sub-module button_channel SHALL implement one channel, instantiated CHANNELS times by a generate loop; the top has no other logic.

Verification (CHANNELS=4, CNT_WIDTH=4, HOLD_WIDTH=8, LONG_CYCLES=32, ACTIVE_LOW=4'b1000)
REQ-031 Clean press ch0 at edge 0, held -> level[0] rises at edge 18; press_pulse[0] one cycle at edge 18; other channels stay 0.
REQ-032 Bounce ch1: high 10 cycles, low 3, then high -> level[1] rises at edge 24; exactly one press_pulse.
REQ-033 Held ch2 -> long_press[2] and long_pulse[2] assert 33 edges after level[2] rises; release clears long_press with level; one release_pulse.
REQ-034 ch3 pin driven 0 (active-low press) -> level[3] rises after 18 edges; pin 1 -> release_pulse[3] after 18 edges.
REQ-035 reset_n low at edge 12 of a ch0 press, released at edge 20 with button held -> outputs 0 in reset, level[0] rises at edge 38, no spurious pulses.
REQ-036 Simultaneous presses on all 4 channels -> all press_pulse bits high in the same cycle.
